// File: rtl/instruction_fetch.sv
// Two-word instruction fetch sequencer: owns the PC, fetches inst1/inst2 pairs and
// applies jump/halt/pause results. Define IFETCH_RETIRE_CNT_EN to build the retire counter.
module instruction_fetch #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_data,
    output logic [15:0]       inst1,
    output logic [15:0]       inst2,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt,
    input  logic              button_pause,
    input  logic              button_continue,
    output logic              paused,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired_count
);

    localparam int unsigned WORD_W = 16;

    typedef enum logic [2:0] {
        FETCH_A,
        FETCH_B,
        CAPTURE,
        EXEC,
        PAUSE,
        HALT
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [WORD_W-1:0]   inst1_q, inst1_d;
    logic [WORD_W-1:0]   inst2_q, inst2_d;
    logic                pause_done_q, pause_done_d;
    logic                cont_q, cont_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= FETCH_A;
            pc_q         <= '0;
            inst1_q      <= '0;
            inst2_q      <= '0;
            pause_done_q <= 1'b0;
            cont_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst1_q      <= inst1_d;
            inst2_q      <= inst2_d;
            pause_done_q <= pause_done_d;
            cont_q       <= cont_d;
        end
    end

    // Next-state, datapath updates and state-decoded outputs
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst1_d      = inst1_q;
        inst2_d      = inst2_q;
        pause_done_d = pause_done_q;
        cont_d       = button_continue;
        imem_rd      = 1'b0;
        imem_addr    = pc_q;
        inst_valid   = 1'b0;
        paused       = 1'b0;
        halted       = 1'b0;

        case (state_q)
            FETCH_A: begin
                imem_rd = 1'b1;
                state_d = FETCH_B;
            end
            FETCH_B: begin
                imem_rd   = 1'b1;
                imem_addr = pc_q + ADDR_W'(1);
                inst1_d   = imem_data;
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                inst2_d = imem_data;
                state_d = EXEC;
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (halt) begin
                    state_d = HALT;
                end else if (button_pause && !pause_done_q) begin
                    state_d = PAUSE;
                end else if (inst_ready) begin
                    state_d      = FETCH_A;
                    pause_done_d = 1'b0;
                    pc_d         = jump ? jump_target : pc_q + ADDR_W'(2);
                end
            end
            PAUSE: begin
                paused = 1'b1;
                // Only a fresh low-to-high operator press releases the pause
                if (button_continue && !cont_q) begin
                    pause_done_d = 1'b1;
                    state_d      = EXEC;
                end
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = FETCH_A;
            end
        endcase
    end

    assign pc    = pc_q;
    assign inst1 = inst1_q;
    assign inst2 = inst2_q;

`ifdef IFETCH_RETIRE_CNT_EN
    logic              consume_c;
    logic [WORD_W-1:0] retired_q, retired_d;

    // EXEC leaves for FETCH_A only when the instruction is consumed
    assign consume_c = (state_q == EXEC) && (state_d == FETCH_A);

    always_comb begin
        retired_d = retired_q;
        if (consume_c && (retired_q != '1)) begin
            retired_d = retired_q + WORD_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign retired_count = retired_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected instruction pairs are queued as the
// PC is steered and popped when inst_valid rises.
module tb_instruction_fetch;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              imem_rd;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_data = '0;
    logic [15:0]       inst1;
    logic [15:0]       inst2;
    logic              inst_valid;
    logic              inst_ready;
    logic              jump;
    logic [ADDR_W-1:0] jump_target;
    logic              halt;
    logic              button_pause;
    logic              button_continue;
    logic              paused;
    logic              halted;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       retired_count;

    instruction_fetch #(.ADDR_W(ADDR_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .inst1          (inst1),
        .inst2          (inst2),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .jump           (jump),
        .jump_target    (jump_target),
        .halt           (halt),
        .button_pause   (button_pause),
        .button_continue(button_continue),
        .paused         (paused),
        .halted         (halted),
        .pc             (pc),
        .retired_count  (retired_count)
    );

    always #5 clock = ~clock;

    logic [15:0] mem [DEPTH];

    always @(posedge clock) begin
        if (imem_rd) imem_data <= mem[imem_addr];
    end

    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [15:0]       i1;
        logic [15:0]       i2;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ret    = 0;
    int   cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic [15:0] ret_exp(input int n);
`ifdef IFETCH_RETIRE_CNT_EN
        return 16'(n);
`else
        return 16'(n * 0);
`endif
    endfunction

    task automatic push_exp(input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] p1;
        p1 = p + ADDR_W'(1);
        sb_q.push_back('{pc: p, i1: mem[p], i2: mem[p1]});
    endtask

    task automatic wait_valid(output int cycles);
        exp_t e;
        cycles = 0;
        while (!inst_valid && cycles < 64) begin
            step();
            cycles++;
        end
        if (!inst_valid) begin
            check("valid_timeout", 32'(inst_valid), 32'(1));
            return;
        end
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'(1));
            return;
        end
        e = sb_q.pop_front();
        check("sb_pc", 32'(pc), 32'(e.pc));
        check("sb_inst1", 32'(inst1), 32'(e.i1));
        check("sb_inst2", 32'(inst2), 32'(e.i2));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; inst_ready = 1'b0; jump = 1'b0; jump_target = '0;
        halt = 1'b0; button_pause = 1'b0; button_continue = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 16'(i * 263 + 16'h1111);
        mem[0] = 16'hC400; mem[1] = 16'h0005; mem[2] = 16'h7000; mem[3] = 16'h0000;

        // Reset state
        repeat (3) step();
        check("rst_valid", 32'(inst_valid), 32'(0));
        check("rst_paused", 32'(paused), 32'(0));
        check("rst_halted", 32'(halted), 32'(0));
        check("rst_pc", 32'(pc), 32'(0));
        check("rst_inst1", 32'(inst1), 32'(0));
        check("rst_retired", 32'(retired_count), 32'(0));
        check("rst_imem_rd", 32'(imem_rd), 32'(1));
        check("rst_imem_addr", 32'(imem_addr), 32'(0));

        // Basic fetch with inst_ready held high
        reset = 1'b1; inst_ready = 1'b1;
        push_exp(ADDR_W'(0));
        wait_valid(cyc);
        check("first_latency", 32'(cyc), 32'(3));
        n_ret++;
        push_exp(ADDR_W'(2));
        step();
        wait_valid(cyc);
        check("refetch_latency", 32'(cyc), 32'(3));
        n_ret++;
        step();
        check("seq_pc", 32'(pc), 32'(4));
        push_exp(ADDR_W'(4));
        wait_valid(cyc);

        // Jump
        jump = 1'b1; jump_target = ADDR_W'(8'h20);
        step();
        n_ret++;
        jump = 1'b0; inst_ready = 1'b0;
        check("jump_fa_rd", 32'(imem_rd), 32'(1));
        check("jump_fa_addr", 32'(imem_addr), 32'(8'h20));
        step();
        check("jump_fb_addr", 32'(imem_addr), 32'(8'h21));
        push_exp(ADDR_W'(8'h20));
        wait_valid(cyc);
        check("retired_3", 32'(retired_count), 32'(ret_exp(n_ret)));
        repeat (2) step();
        check("hold_valid", 32'(inst_valid), 32'(1));
        check("hold_inst1", 32'(inst1), 32'(mem[8'h20]));

        // Pause with continue held high from before entry
        button_continue = 1'b1; button_pause = 1'b1;
        step();
        check("pause_paused", 32'(paused), 32'(1));
        check("pause_valid", 32'(inst_valid), 32'(0));
        check("pause_rd", 32'(imem_rd), 32'(0));
        inst_ready = 1'b1;
        repeat (3) step();
        check("pause_no_edge", 32'(paused), 32'(1));
        button_continue = 1'b0;
        step();
        check("pause_low", 32'(paused), 32'(1));
        button_continue = 1'b1;
        step();
        check("resume_valid", 32'(inst_valid), 32'(1));
        check("resume_paused", 32'(paused), 32'(0));
        check("resume_inst1", 32'(inst1), 32'(mem[8'h20]));
        step();
        n_ret++;
        check("no_repause", 32'(paused), 32'(0));
        check("post_pause_addr", 32'(imem_addr), 32'(8'h22));
        inst_ready = 1'b0; button_pause = 1'b0; button_continue = 1'b0;
        push_exp(ADDR_W'(8'h22));
        wait_valid(cyc);

        // Halt wins over pause, ready and jump
        halt = 1'b1; button_pause = 1'b1; inst_ready = 1'b1;
        jump = 1'b1; jump_target = ADDR_W'(8'h40);
        step();
        check("halt_halted", 32'(halted), 32'(1));
        check("halt_paused", 32'(paused), 32'(0));
        check("halt_valid", 32'(inst_valid), 32'(0));
        check("halt_pc", 32'(pc), 32'(8'h22));
        check("halt_retired", 32'(retired_count), 32'(ret_exp(n_ret)));
        repeat (4) step();
        check("halt_stay", 32'(halted), 32'(1));
        check("halt_rd", 32'(imem_rd), 32'(0));
        check("halt_inst1", 32'(inst1), 32'(mem[8'h22]));
        halt = 1'b0; button_pause = 1'b0; inst_ready = 1'b0; jump = 1'b0;

        // Reset out of HALT
        reset = 1'b0;
        step();
        check("hrst_halted", 32'(halted), 32'(0));
        check("hrst_pc", 32'(pc), 32'(0));
        check("hrst_inst2", 32'(inst2), 32'(0));
        check("hrst_retired", 32'(retired_count), 32'(0));
        reset = 1'b1; n_ret = 0;
        push_exp(ADDR_W'(0));
        wait_valid(cyc);
        check("restart_latency", 32'(cyc), 32'(3));

        // PC wrap
        jump = 1'b1; jump_target = '1; inst_ready = 1'b1;
        step();
        n_ret++;
        jump = 1'b0; inst_ready = 1'b0;
        check("wrap_fa_addr", 32'(imem_addr), 32'(DEPTH - 1));
        step();
        check("wrap_fb_addr", 32'(imem_addr), 32'(0));
        push_exp('1);
        wait_valid(cyc);
        inst_ready = 1'b1;
        step();
        n_ret++;
        inst_ready = 1'b0;
        check("wrap_next_pc", 32'(pc), 32'(1));
        push_exp(ADDR_W'(1));
        wait_valid(cyc);
        check("retired_wrap", 32'(retired_count), 32'(ret_exp(n_ret)));

        // Reset asserted during FETCH_B
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        step();
        check("fb_before_rst", 32'(imem_addr), 32'(4));
        reset = 1'b0;
        step();
        check("fbrst_rd", 32'(imem_rd), 32'(1));
        check("fbrst_addr", 32'(imem_addr), 32'(0));
        check("fbrst_inst1", 32'(inst1), 32'(0));
        check("fbrst_pc", 32'(pc), 32'(0));
        reset = 1'b1;
        push_exp(ADDR_W'(0));
        wait_valid(cyc);
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Two-word instruction fetch sequencer feeding the control unit. Reads consecutive 16-bit words from a synchronous-read instruction memory, presents them as the `inst1`/`inst2` pair, and holds them stable while the control unit decodes. Owns the program counter and applies the control unit's `jump`, `halt` and `button_pause` results to instruction sequencing.

## Interface
- `ADDR_W`, 8: instruction memory word-address width; PC width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `imem_rd`  out  1  read strobe to instruction memory.
- `imem_addr`  out  ADDR_W  word address to instruction memory.
- `imem_data`  in  16  read data, valid the cycle after `imem_rd`.
- `inst1`  out  16  first instruction word: opcode, optype, op1.
- `inst2`  out  16  second instruction word: op2, op3.
- `inst_valid`  out  1  `inst1`/`inst2` may be executed this cycle.
- `inst_ready`  in  1  datapath consumes the instruction this cycle.
- `jump`  in  1  control unit jump decision for the held instruction.
- `jump_target`  in  ADDR_W  next PC when `jump` is taken.
- `halt`  in  1  control unit halt decode for the held instruction.
- `button_pause`  in  1  held instruction is an I/O instruction that waits for the operator.
- `button_continue`  in  1  operator confirm, level input, debounced externally.
- `paused`  out  1  waiting for operator.
- `halted`  out  1  halt reached.
- `pc`  out  ADDR_W  address of `inst1` of the held instruction.
- `retired_count`  out  16  consumed-instruction count. See Configuration.

## Operation
- States: FETCH_A, FETCH_B, CAPTURE, EXEC, PAUSE, HALT.
- FETCH_A: `imem_rd`=1, `imem_addr`=`pc`. Next state is FETCH_B.
- FETCH_B: `imem_rd`=1, `imem_addr`=`pc`+1 (mod 2^ADDR_W). Register `imem_data` into `inst1`. Next state is CAPTURE.
- CAPTURE: register `imem_data` into `inst2`. Next state is EXEC.
- EXEC: `inst_valid`=1. Priority order:
  - `halt` → HALT.
  - `button_pause` with `pause_done`=0 → PAUSE.
  - `inst_ready` → FETCH_A, clear `pause_done`, and update `pc`: `jump_target` if `jump`=1, else `pc`+2, both modulo 2^ADDR_W.
  - Otherwise stay in EXEC.
- PAUSE: `inst_valid`=0, `paused`=1. A rising edge on `button_continue` sets `pause_done`=1 and moves to EXEC. The edge detector is a registered copy of `button_continue`.
- HALT: `inst_valid`=0, `halted`=1. The block stays here until reset.
- `imem_rd`=0 in EXEC, PAUSE and HALT. `imem_addr` holds `pc` in those states.
- `inst1`/`inst2` change only in FETCH_B and CAPTURE. They stay stable through EXEC, PAUSE and HALT.
- `jump`, `jump_target`, `halt` and `button_pause` are sampled only in EXEC. Values in other states are ignored.
- `button_continue` edges outside PAUSE are ignored.

## Timing
- Reset (`reset`=0 at a rising edge), from any state including mid-fetch or PAUSE:
  - state returns to FETCH_A;
  - `pc`, `inst1`, `inst2`, `retired_count`, `pause_done` and the continue-edge register clear to 0;
  - `inst_valid`, `paused` and `halted` are 0.
- In FETCH_A, `imem_rd`=1 combinationally.
- First `inst_valid` appears 3 cycles after the first cycle in FETCH_A.
- With `inst_ready` held at 1, throughput is 4 cycles per instruction.
- Consumption happens at a rising edge in EXEC with `inst_ready`=1. The `pc` update is visible the next cycle.
- When `halt` and `button_pause` are both high in EXEC, `halt` wins.
- PC wrap: from `pc`=2^ADDR_W−1, FETCH_B reads address 0, and the next sequential `pc`=1.

## Configuration
- `IFETCH_RETIRE_CNT_EN` defined: `retired_count` increments by 1 on every consumption. It saturates at 16'hFFFF and clears on reset.
- `IFETCH_RETIRE_CNT_EN` undefined: `retired_count` is constant 0 and no counter logic is built. The port list is identical in both builds.

## Test plan
- Reset, then memory words 0..3 = 16'hC400, 16'h0005, 16'h7000, 16'h0000, with `inst_ready`=1:
  - `inst_valid` first high in cycle 3 with `inst1`=16'hC400 and `inst2`=16'h0005;
  - the next instruction is valid in cycle 7 with `pc`=2.
- Jump: in EXEC at `pc`=4 with `jump`=1 and `jump_target`=8'h20 → the next FETCH_A drives `imem_addr`=8'h20 and FETCH_B drives 8'h21.
- Pause: `button_pause`=1 in EXEC → `paused`=1 and `inst_valid`=0. Holding `button_continue` high from before entry causes no release. A low-then-high `button_continue` → EXEC and consumption, with no re-pause.
- Halt: `halt`=1 together with `button_pause`=1 and `inst_ready`=1 → HALT, `halted`=1, `pc` unchanged, `retired_count` unchanged. Reset → `pc`=0 and fetch restarts.
- Wrap and reset:
  - `ADDR_W`=4 at `pc`=15 → addresses 15 then 0, and next `pc`=1.
  - Reset asserted in FETCH_B → the next cycle is FETCH_A with `imem_addr`=0 and `inst1`=0.
- Build with `IFETCH_RETIRE_CNT_EN`: 3 consumptions → `retired_count`=3. Build without the macro: `retired_count`=0 throughout.
